// File: rtl/serial_alu.sv
// serial_alu: WIDTH-bit ALU evaluated DIGIT bits per cycle, LSB first,
// with valid/ready handshakes on operands and result.
module serial_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d;
  logic [2:0]       ctl_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] out_q;
  logic             carryout_q, overflow_q, zero_q, negative_q;

  logic             accept_c, last_c, is_arith_c, is_logic_c;
  logic [DIGIT-1:0] a_s, b_s, sum_s, logic_s, res_s;
  logic [DIGIT:0]   chain;
  logic [WIDTH+DIGIT-1:0] cat_c;

  assign accept_c   = (state_q == S_IDLE) && in_valid;
  assign last_c     = (cnt_q == CNT_W'(N - 1));
  assign is_arith_c = (ctl_q[2:1] == 2'b01);
  assign is_logic_c = ctl_q[2];
  assign a_s        = a_q[DIGIT-1:0];
  assign b_s        = b_q[DIGIT-1:0];

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_BUSY;
      S_BUSY:  if (last_c) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register only
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE:  in_ready  = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // DIGIT-bit ripple carry chain for the current slice
  always_comb begin
    chain    = '0;
    chain[0] = carry_q;
    for (int i = 0; i < int'(DIGIT); i++) begin
      chain[i+1] = (a_s[i] & b_s[i]) | (chain[i] & (a_s[i] ^ b_s[i]));
    end
  end

  assign sum_s = a_s ^ b_s ^ chain[DIGIT-1:0];

  // Logic slice selected by the low control bits
  always_comb begin
    logic_s = '0;
    case (ctl_q[1:0])
      2'b00:   logic_s = a_s & b_s;
      2'b01:   logic_s = a_s | b_s;
      2'b10:   logic_s = ~(a_s | b_s);
      default: logic_s = a_s ^ b_s;
    endcase
  end

  // Slice result; illegal ops contribute zeros
  always_comb begin
    res_s = '0;
    if (is_logic_c) begin
      res_s = logic_s;
    end else if (is_arith_c) begin
      res_s = sum_s;
    end
  end

  // New slice enters the accumulator from the top
  assign cat_c = {res_s, acc_q};
  assign acc_d = cat_c[WIDTH+DIGIT-1:DIGIT];

  // Operand shift registers, carry, counter and captured result/flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q        <= '0;
      b_q        <= '0;
      ctl_q      <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      out_q      <= '0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b1;
      negative_q <= 1'b0;
    end else begin
      if (accept_c) begin
        a_q     <= A;
        b_q     <= (control[0] && !control[2]) ? ~B : B;
        ctl_q   <= control;
        carry_q <= control[0] && !control[2];
        cnt_q   <= '0;
      end else if (state_q == S_BUSY) begin
        a_q     <= a_q >> DIGIT;
        b_q     <= b_q >> DIGIT;
        carry_q <= chain[DIGIT];
        acc_q   <= acc_d;
        cnt_q   <= cnt_q + CNT_W'(1);
        if (last_c) begin
          out_q      <= acc_d;
          carryout_q <= is_arith_c && chain[DIGIT];
          overflow_q <= is_arith_c && (chain[DIGIT] ^ chain[DIGIT-1]);
          zero_q     <= (acc_d == '0);
          negative_q <= acc_d[WIDTH-1];
        end
      end
    end
  end

  assign out      = out_q;
  assign carryout = carryout_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;
  assign negative = negative_q;

endmodule

// File: tb/tb_serial_alu.sv
// tb_serial_alu: directed checks of serial_alu at WIDTH=8 with DIGIT=1 and DIGIT=4
// instances driven by the same stimulus.
module tb_serial_alu;

  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_NOR = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  logic       clock, reset_n;
  logic       in_valid, out_ready;
  logic [7:0] a_in, b_in;
  logic [2:0] control;

  logic       in_ready1, out_valid1, carryout1, overflow1, zero1, negative1;
  logic [7:0] out1;
  logic       in_ready4, out_valid4, carryout4, overflow4, zero4, negative4;
  logic [7:0] out4;

  int checks   = 0;
  int failures = 0;
  int lat1, lat4;
  logic [11:0] r1, r4;

  serial_alu #(.WIDTH(8), .DIGIT(1)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
    .A(a_in), .B(b_in), .control(control), .out_valid(out_valid1),
    .out_ready(out_ready), .out(out1), .carryout(carryout1), .overflow(overflow1),
    .zero(zero1), .negative(negative1)
  );

  serial_alu #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready4),
    .A(a_in), .B(b_in), .control(control), .out_valid(out_valid4),
    .out_ready(out_ready), .out(out4), .carryout(carryout4), .overflow(overflow4),
    .zero(zero4), .negative(negative4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [11:0] fl(input bit co, input bit ov, input bit z,
                                     input bit n, input logic [7:0] o);
    return {co, ov, z, n, o};
  endfunction

  function automatic logic [11:0] pk1();
    return {carryout1, overflow1, zero1, negative1, out1};
  endfunction

  function automatic logic [11:0] pk4();
    return {carryout4, overflow4, zero4, negative4, out4};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Present one op for a single accepting edge, then scramble the inputs
  task automatic start_op(input logic [2:0] ctl, input logic [7:0] a, input logic [7:0] b);
    @(negedge clock);
    in_valid  = 1'b1;
    control   = ctl;
    a_in      = a;
    b_in      = b;
    out_ready = 1'b0;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    a_in     = ~a;
    b_in     = 8'h5A;
    control  = OP_XOR;
  endtask

  // Poll both instances until each raises out_valid (bounded)
  task automatic collect();
    lat1 = 0;
    lat4 = 0;
    r1   = '0;
    r4   = '0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clock);
      #1;
      if (lat1 == 0 && out_valid1) begin
        lat1 = cyc;
        r1   = pk1();
      end
      if (lat4 == 0 && out_valid4) begin
        lat4 = cyc;
        r4   = pk4();
      end
      if (lat1 != 0 && lat4 != 0) break;
    end
  endtask

  // Drain both results and confirm return to IDLE
  task automatic finish_op(input string tag);
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    check_eq({tag, "_idle"}, {in_ready1, in_ready4, out_valid1, out_valid4}, 4'b1100);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] ctl, input logic [7:0] a,
                        input logic [7:0] b, input logic [11:0] exp);
    start_op(ctl, a, b);
    collect();
    check_eq({tag, "_lat1"}, lat1, 8);
    check_eq({tag, "_lat4"}, lat4, 2);
    check_eq({tag, "_res1"}, r1, exp);
    check_eq({tag, "_res4"}, r4, exp);
    finish_op(tag);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    control   = '0;
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_hs", {in_ready1, in_ready4, out_valid1, out_valid4}, 4'b1100);
    check_eq("rst_res1", pk1(), fl(0, 0, 1, 0, 8'h00));
    check_eq("rst_res4", pk4(), fl(0, 0, 1, 0, 8'h00));
    @(negedge clock);
    reset_n = 1'b1;

    run_op("add7f",  OP_ADD, 8'h7F, 8'h01, fl(0, 1, 0, 1, 8'h80));
    run_op("sub55",  OP_SUB, 8'h05, 8'h05, fl(1, 0, 1, 0, 8'h00));
    run_op("sub35",  OP_SUB, 8'h03, 8'h05, fl(0, 0, 0, 1, 8'hFE));
    run_op("add80",  OP_ADD, 8'h80, 8'h80, fl(1, 1, 1, 0, 8'h00));
    run_op("and",    OP_AND, 8'hC3, 8'h5A, fl(0, 0, 0, 0, 8'h42));
    run_op("or",     OP_OR,  8'h81, 8'h02, fl(0, 0, 0, 1, 8'h83));
    run_op("nor",    OP_NOR, 8'hF0, 8'h0F, fl(0, 0, 1, 0, 8'h00));
    run_op("ill1",   3'd1,   8'h12, 8'h34, fl(0, 0, 1, 0, 8'h00));
    run_op("ill0",   3'd0,   8'hFF, 8'hFF, fl(0, 0, 1, 0, 8'h00));
    run_op("xor",    OP_XOR, 8'hAA, 8'hFF, fl(0, 0, 0, 0, 8'h55));

    // Backpressure: result held, second request waits for the handshake
    start_op(OP_ADD, 8'h12, 8'h34);
    collect();
    check_eq("bp_lat1", lat1, 8);
    check_eq("bp_res1", r1, fl(0, 0, 0, 0, 8'h46));
    check_eq("bp_res4", r4, fl(0, 0, 0, 0, 8'h46));
    @(negedge clock);
    in_valid = 1'b1;
    control  = OP_XOR;
    a_in     = 8'h0F;
    b_in     = 8'hF0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clock);
      #1;
      check_eq("bp_hold1", pk1(), fl(0, 0, 0, 0, 8'h46));
      check_eq("bp_hold4", pk4(), fl(0, 0, 0, 0, 8'h46));
      check_eq("bp_hs", {in_ready1, in_ready4, out_valid1, out_valid4}, 4'b0011);
    end
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    check_eq("bp_release", {in_ready1, in_ready4, out_valid1, out_valid4}, 4'b1100);
    out_ready = 1'b0;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    check_eq("bp_accept2", {in_ready1, in_ready4}, 2'b00);
    collect();
    check_eq("bp2_lat1", lat1, 8);
    check_eq("bp2_lat4", lat4, 2);
    check_eq("bp2_res1", r1, fl(0, 0, 0, 1, 8'hFF));
    check_eq("bp2_res4", r4, fl(0, 0, 0, 1, 8'hFF));
    finish_op("bp2");

    // Put a nonzero result on the outputs, then abort an op mid-flight
    run_op("xor2", OP_XOR, 8'h0F, 8'h33, fl(0, 0, 0, 0, 8'h3C));
    start_op(OP_ADD, 8'h11, 8'h22);
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_hs", {in_ready1, in_ready4, out_valid1, out_valid4}, 4'b1100);
    check_eq("mid_rst_res1", pk1(), fl(0, 0, 1, 0, 8'h00));
    check_eq("mid_rst_res4", pk4(), fl(0, 0, 1, 0, 8'h00));
    @(negedge clock);
    reset_n = 1'b1;
    run_op("addff", OP_ADD, 8'hFF, 8'h01, fl(1, 0, 1, 0, 8'h00));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
